// File: rtl/nios_system_led_sequencer.sv
// rtl/nios_system_led_sequencer.sv - LED PIO master: pattern-table sequencer merged with event set/clear requests
//
// Purpose: owns the 8-bit LED PIO slave (data @0, bit-set @4, bit-clear @5).
// Plays a CPU-loaded table of up to 8 patterns at a programmable step period
// and merges one-cycle set/clear event pulses into the same PIO, issuing at
// most one PIO write per clock (priority: clear, set, pattern step).
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   s_address/s_chipselect/
//   s_write_n/s_writedata         config slave write port
//   s_readdata                    config slave read data (combinational)
//   evt_set, evt_clr              one-cycle LED bit set/clear request pulses
//   m_address/m_chipselect/
//   m_write_n/m_writedata         PIO master write port
//   busy                          sequence running
module nios_system_led_sequencer #(
    parameter int PERIOD_W     = 24,
    parameter int RESET_PERIOD = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic [7:0]  evt_set,
    input  logic [7:0]  evt_clr,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PERIOD = 3'd1;
    localparam logic [2:0] A_LENGTH = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_PATLO  = 3'd4;
    localparam logic [2:0] A_PATHI  = 3'd5;

    // configuration
    logic                r_en;
    logic                r_oneshot;
    logic [PERIOD_W-1:0] r_period;
    logic [2:0]          r_length;
    logic [7:0][7:0]     r_pat;

    // sequencer
    logic [0:0]          r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [2:0]          r_idx;
    logic                r_busy;

    // pending PIO requests
    logic [7:0]          r_clr_pend;
    logic [7:0]          r_set_pend;
    logic                r_step_pend;
    logic [2:0]          r_idx_out;

    logic                w_wr;
    logic                w_ctrl_wr;
    logic                w_start;
    logic                w_abort;
    logic                w_tick;
    logic                w_last;
    logic                w_finish;
    logic                w_advance;
    logic [2:0]          w_next_idx;
    logic                w_step_new;
    logic [2:0]          w_step_new_idx;
    logic [PERIOD_W-1:0] w_reload;
    logic                w_svc_clr;
    logic                w_svc_set;
    logic                w_svc_step;
    logic [31:0]         w_period_rd;

    assign w_wr      = s_chipselect & ~s_write_n;
    assign w_ctrl_wr = w_wr & (s_address == A_CTRL);

    // A PERIOD of 0 behaves as 1, i.e. the counter reloads to 0.
    assign w_reload = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);

    // EN is only ever 1 while running, so an EN=1 write in IDLE is a 0->1 edge.
    assign w_start = w_ctrl_wr &  s_writedata[0] & (r_state == ST_IDLE);
    assign w_abort = w_ctrl_wr & ~s_writedata[0] & (r_state == ST_RUN);

    // LENGTH of 0 wraps to last index 7 through 3-bit arithmetic.
    assign w_last     = (r_idx == (r_length - 3'd1));
    assign w_tick     = (r_state == ST_RUN) & (r_cnt == '0) & ~w_abort;
    assign w_finish   = w_tick & w_last & r_oneshot;
    assign w_advance  = w_tick & ~w_finish;
    assign w_next_idx = w_last ? 3'd0 : r_idx + 3'd1;

    assign w_step_new     = w_start | w_advance;
    assign w_step_new_idx = w_start ? 3'd0 : w_next_idx;

    // Fixed-priority service: exactly one request is written per cycle.
    assign w_svc_clr  = |r_clr_pend;
    assign w_svc_set  = ~w_svc_clr & (|r_set_pend);
    assign w_svc_step = ~w_svc_clr & ~(|r_set_pend) & r_step_pend;

    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = 3'd0;
        m_writedata  = 32'd0;
        if (w_svc_clr) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_address    = 3'd5;
            m_writedata  = {24'd0, r_clr_pend};
        end else if (w_svc_set) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_address    = 3'd4;
            m_writedata  = {24'd0, r_set_pend};
        end else if (w_svc_step) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_address    = 3'd0;
            m_writedata  = {24'd0, r_pat[r_idx_out]};
        end
    end

    always_comb begin
        w_period_rd                 = '0;
        w_period_rd[PERIOD_W-1:0]   = r_period;
    end

    always_comb begin
        s_readdata = 32'd0;
        case (s_address)
            A_CTRL:   s_readdata = {30'd0, r_oneshot, r_en};
            A_PERIOD: s_readdata = w_period_rd;
            A_LENGTH: s_readdata = {29'd0, r_length};
            A_STATUS: s_readdata = {23'd0, r_busy, 1'b0, r_idx, 1'b0, r_step_pend,
                                    |r_set_pend, |r_clr_pend};
            A_PATLO:  s_readdata = r_pat[3:0];
            A_PATHI:  s_readdata = r_pat[7:4];
            default:  s_readdata = 32'd0;
        endcase
    end

    assign busy = r_busy;

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_period  <= PERIOD_W'(RESET_PERIOD);
            r_length  <= 3'd0;
            r_pat     <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en      <= s_writedata[0];
                r_oneshot <= s_writedata[1];
            end else if (w_finish) begin
                r_en      <= 1'b0;
            end
            if (w_wr && s_address == A_PERIOD) r_period  <= s_writedata[PERIOD_W-1:0];
            if (w_wr && s_address == A_LENGTH) r_length  <= s_writedata[2:0];
            if (w_wr && s_address == A_PATLO)  r_pat[3:0] <= s_writedata;
            if (w_wr && s_address == A_PATHI)  r_pat[7:4] <= s_writedata;
        end
    end

    // Sequencer FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= w_reload;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (w_abort) begin
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_finish) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_idx   <= w_next_idx;
                        r_cnt   <= w_reload;
                    end else begin
                        r_cnt   <= r_cnt - PERIOD_W'(1);
                    end
                end
            endcase
        end
    end

    // Pending requests: a pulse landing in the cycle its pend is serviced stays
    // pending. A newer step overwrites a still-pending older one's index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_pend  <= 8'd0;
            r_set_pend  <= 8'd0;
            r_step_pend <= 1'b0;
            r_idx_out   <= 3'd0;
        end else begin
            r_clr_pend <= (w_svc_clr ? 8'd0 : r_clr_pend) | evt_clr;
            r_set_pend <= (w_svc_set ? 8'd0 : r_set_pend) | evt_set;
            if (w_abort) begin
                r_step_pend <= 1'b0;
            end else begin
                r_step_pend <= (r_step_pend & ~w_svc_step) | w_step_new;
            end
            if (w_step_new) r_idx_out <= w_step_new_idx;
        end
    end

endmodule

// File: doc/nios_system_led_sequencer.md
Name: nios_system_led_sequencer

Overview:
Avalon-MM controller that owns the 8-bit LED PIO slave (data at address 0, bit-set at address 4, bit-clear at address 5; write_n-strobed, no waitrequest). It plays a CPU-loaded pattern table of up to 8 steps at a programmable period. It also merges asynchronous set/clear event pulses from the accelerator into the same PIO. At most one PIO write is issued per clock, with fixed-priority arbitration between clear, set and pattern-step requests.

Parameters:
PERIOD_W, 24, width of the step-period register and its down-counter
RESET_PERIOD, 1000000, reset value of PERIOD in clock cycles

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_address  in  3  config slave word address
s_chipselect  in  1  config slave select
s_write_n  in  1  config slave write strobe, active low
s_writedata  in  32  config slave write data
s_readdata  out  32  config slave read data, combinational, zero wait states
evt_set  in  8  one-cycle pulses; requested LED bits to set
evt_clr  in  8  one-cycle pulses; requested LED bits to clear
m_address  out  3  to PIO address
m_chipselect  out  1  to PIO chipselect
m_write_n  out  1  to PIO write_n
m_writedata  out  32  to PIO writedata; bits 31:8 are always 0
busy  out  1  sequence running

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low. All registers are cleared on reset except PERIOD, which resets to RESET_PERIOD. Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0.
- Config registers, write when s_chipselect & ~s_write_n:
  - 0 CTRL: bit0 EN, bit1 ONESHOT.
  - 1 PERIOD [PERIOD_W-1:0]; a value of 0 is treated as 1.
  - 2 LENGTH [2:0]; 0 means 8 steps.
  - 3 STATUS, read-only: bit8 busy, bits6:4 step index, bit2 step_pend, bit1 set_pend!=0, bit0 clr_pend!=0.
  - 4 PAT0..3 as bytes [7:0]..[31:24].
  - 5 PAT4..7 as bytes.
  - 6 and 7 read 0; writes to them are ignored.
- Pending registers: clr_pend[7:0], set_pend[7:0], step_pend. Every edge: pend <= (pend & ~serviced) | new. Pulses arriving in the same cycle a pend is serviced stay pending.
- Master output is combinational from the pend registers, with one write per cycle. Priority order:
  1. clr_pend!=0: address 5, data clr_pend.
  2. else set_pend!=0: address 4, data set_pend.
  3. else step_pend: address 0, data PAT[idx_out].
- When any request is pending: m_chipselect=1 and m_write_n=0. Otherwise m_chipselect=0, m_write_n=1, address and data 0.
- The serviced request clears at the end of its cycle. Latency is 1 cycle: an evt pulse in cycle N produces a PIO write in cycle N+1 when nothing of higher priority is pending.
- Sequencer FSM:
  - IDLE: on an EN 0->1 write, load cnt=max(PERIOD,1)-1, idx=0, set step_pend for step 0, busy=1, go to RUN.
  - RUN: cnt decrements each cycle. At cnt==0:
    - If idx is the last step (LENGTH-1) and ONESHOT=1: clear EN, busy=0, go to IDLE.
    - Otherwise: idx <= (idx==last)?0:idx+1, set step_pend with that index, reload cnt.
- idx_out is latched when step_pend is set. A step that is deferred by events writes its latched pattern. If step_pend is still set when the next step fires, the newer index overwrites it.
- Writing EN=0 in RUN: go to IDLE, busy=0, idx=0, drop step_pend. Event pends are unaffected.
- Writing PERIOD or LENGTH in RUN takes effect at the next reload or wrap.
- A step write at address 0 overwrites bits set by earlier events; this is intended.
- evt_set and evt_clr hitting the same bit in one cycle: both pends record it. Clear is written first, then set, so the final LED bit is 1.

Test Plan:
- Reset: after reset_n release, s_readdata@addr1=RESET_PERIOD, busy=0, m_chipselect=0, and no PIO writes occur for 20 cycles.
- Event: evt_set=0x0F for 1 cycle at N -> PIO write addr4 data 0x0F in N+1 and nothing in N+2. evt_set=0x01 and evt_clr=0x01 together -> addr5 0x01, then addr4 0x01 on consecutive cycles.
- Loop: PAT0..2=0x11,0x22,0x44, PERIOD=4, LENGTH=3, CTRL=1 -> writes addr0 0x11, 0x22, 0x44, 0x11, ... spaced exactly 4 cycles apart, with the first write in the cycle after the CTRL write.
- Oneshot: CTRL=3, LENGTH=2 -> exactly two addr0 writes, then busy=0 and CTRL reads 0x2.
- Collision: evt_clr pulse in the cycle before a step fires -> addr5 write first, then the addr0 step write 1 cycle late with the correct pattern, and the next step still lands on the original period grid.
- Abort: CTRL=0 while step_pend is set -> no addr0 write, STATUS idx=0, busy=0. A pending event still completes.
